// File: rtl/fetch_queue.sv
// Decoupled RV32I fetch stage: owns the fetch PC, drives the I-cache, buffers {pc, ir} pairs in a DEPTH-entry FIFO.
// Latency: resp at cycle N is visible at the head at N+1; redirect empties the queue by N+1. Optional macro: FETCH_QUEUE_PERF_EN.
// Backpressure: requests stop while the FIFO is full; the address is held until resp.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h60000000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       instr_read,
    output logic [31:0]                instr_mem_address,
    input  logic [31:0]                instr_mem_rdata,
    input  logic                       instr_mem_resp,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       id_ready,
    output logic                       if_valid,
    output logic [31:0]                if_pc,
    output logic [31:0]                if_ir,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_discards
`endif
);

    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          PW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {
        S_FETCH   = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_fetch_pc_nxt;
    logic [31:0]     r_pend_pc;
    logic [31:0]     w_pend_pc_nxt;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [31:0]     r_mem_pc [DEPTH];
    logic [31:0]     r_mem_ir [DEPTH];

    logic            w_full;
    logic            w_push;
    logic            w_pop;

    assign w_full            = (r_count == CW'(DEPTH));
    // In DISCARD the aborted read is still outstanding, so the request stays up regardless of occupancy.
    assign instr_read        = rst && ((r_state == S_DISCARD) || !w_full);
    assign instr_mem_address = r_fetch_pc;

    assign w_push = (r_state == S_FETCH) && instr_read && instr_mem_resp && !redirect;
    assign w_pop  = if_valid && id_ready && !redirect;

    assign if_valid  = rst && (r_count != '0);
    assign if_pc     = if_valid ? r_mem_pc[r_rd_ptr] : 32'h0;
    assign if_ir     = if_valid ? r_mem_ir[r_rd_ptr] : NOP;
    assign buf_count = r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_pend_pc_nxt  = r_pend_pc;
        case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    // A read still waiting for its resp must be drained before the new target is issued.
                    if (instr_read && !instr_mem_resp) begin
                        w_state_nxt   = S_DISCARD;
                        w_pend_pc_nxt = redirect_pc;
                    end else begin
                        w_fetch_pc_nxt = redirect_pc;
                    end
                end else if (w_push) begin
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                end
            end
            S_DISCARD: begin
                if (instr_mem_resp) begin
                    w_state_nxt    = S_FETCH;
                    w_fetch_pc_nxt = redirect ? redirect_pc : r_pend_pc;
                end else if (redirect) begin
                    w_pend_pc_nxt = redirect_pc;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            if (redirect) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr] <= r_fetch_pc;
            r_mem_ir[r_wr_ptr] <= instr_mem_rdata;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_perf_full_cycles;
    logic [31:0] r_perf_discards;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_full_cycles <= '0;
            r_perf_discards    <= '0;
        end else begin
            if (w_full && (r_perf_full_cycles != 32'hFFFFFFFF)) begin
                r_perf_full_cycles <= r_perf_full_cycles + 32'd1;
            end
            // Covers both the abort that enters DISCARD and the redirect that lands on a resp.
            if ((r_state == S_FETCH) && redirect && instr_read && (r_perf_discards != 32'hFFFFFFFF)) begin
                r_perf_discards <= r_perf_discards + 32'd1;
            end
        end
    end

    assign perf_full_cycles = r_perf_full_cycles;
    assign perf_discards    = r_perf_discards;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): reset, streaming, full, redirects, push+pop, reset during discard.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic [31:0] instr_mem_rdata;
    logic        instr_mem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_ir;
    logic [2:0]  buf_count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_discards;
`endif

    int n_chk = 0;
    int n_err = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h60000000)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_read        (instr_read),
        .instr_mem_address (instr_mem_address),
        .instr_mem_rdata   (instr_mem_rdata),
        .instr_mem_resp    (instr_mem_resp),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .id_ready          (id_ready),
        .if_valid          (if_valid),
        .if_pc             (if_pc),
        .if_ir             (if_ir),
        .buf_count         (buf_count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_full_cycles  (perf_full_cycles),
        .perf_discards     (perf_discards)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        instr_mem_resp = 1'b0;
        redirect       = 1'b0;
        id_ready       = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst             = 1'b0;
        instr_mem_rdata = 32'h0;
        instr_mem_resp  = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        id_ready        = 1'b0;
        tick();
        tick();
        chk("rst_read",  32'(instr_read), 32'd0);
        chk("rst_valid", 32'(if_valid),   32'd0);
        chk("rst_pc",    if_pc,           32'h0);
        chk("rst_ir",    if_ir,           32'h00000013);
        chk("rst_count", 32'(buf_count),  32'd0);

        // Streaming with ID always ready
        rst = 1'b1;
        #1;
        chk("t1_read",   32'(instr_read),  32'd1);
        chk("t1_addr0",  instr_mem_address, 32'h60000000);
        chk("t1_novld",  32'(if_valid),    32'd0);
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'hA0000000;
        id_ready        = 1'b1;
        tick();
        chk("t1_vld0",   32'(if_valid),    32'd1);
        chk("t1_pc0",    if_pc,            32'h60000000);
        chk("t1_ir0",    if_ir,            32'hA0000000);
        chk("t1_addr1",  instr_mem_address, 32'h60000004);
        instr_mem_rdata = 32'hA0000001;
        tick();
        chk("t1_pc1",    if_pc,            32'h60000004);
        chk("t1_ir1",    if_ir,            32'hA0000001);
        chk("t1_cnt1",   32'(buf_count),   32'd1);
        instr_mem_rdata = 32'hA0000002;
        tick();
        chk("t1_pc2",    if_pc,            32'h60000008);
        chk("t1_ir2",    if_ir,            32'hA0000002);

        // Fill to DEPTH, then release one entry
        do_reset();
        instr_mem_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr_mem_rdata = 32'hB0000000 + 32'(i);
            tick();
        end
        chk("t2_full_cnt",  32'(buf_count),   32'd4);
        chk("t2_full_read", 32'(instr_read),  32'd0);
        chk("t2_head",      if_pc,            32'h60000000);
        instr_mem_resp = 1'b0;
        id_ready       = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("t2_cnt3",  32'(buf_count),   32'd3);
        chk("t2_read",  32'(instr_read),  32'd1);
        chk("t2_addr",  instr_mem_address, 32'h60000010);
        chk("t2_pc",    if_pc,            32'h60000004);
        chk("t2_ir",    if_ir,            32'hB0000001);
`ifdef FETCH_QUEUE_PERF_EN
        chk("t2_perf_full", perf_full_cycles, 32'd1);
`endif

        // Redirect while a read is outstanding
        do_reset();
        id_ready        = 1'b1;
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'hC0000000;
        tick();
        instr_mem_rdata = 32'hC0000001;
        tick();
        instr_mem_resp = 1'b0;
        id_ready       = 1'b0;
        chk("t3_addr_pre", instr_mem_address, 32'h60000008);
        chk("t3_cnt_pre",  32'(buf_count),    32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h60000100;
        tick();
        redirect = 1'b0;
        chk("t3_flush",   32'(buf_count),    32'd0);
        chk("t3_novld",   32'(if_valid),     32'd0);
        chk("t3_read",    32'(instr_read),   32'd1);
        chk("t3_hold0",   instr_mem_address, 32'h60000008);
        tick();
        chk("t3_hold1",   instr_mem_address, 32'h60000008);
        tick();
        chk("t3_hold2",   instr_mem_address, 32'h60000008);
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'hDEADBEEF;
        tick();
        instr_mem_resp = 1'b0;
        chk("t3_drop_cnt", 32'(buf_count),    32'd0);
        chk("t3_drop_vld", 32'(if_valid),     32'd0);
        chk("t3_new_addr", instr_mem_address, 32'h60000100);
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'hC0000100;
        tick();
        instr_mem_resp = 1'b0;
        chk("t3_new_pc",  if_pc, 32'h60000100);
        chk("t3_new_ir",  if_ir, 32'hC0000100);

        // Redirect coincident with resp
        redirect        = 1'b1;
        redirect_pc     = 32'h60000200;
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'hDDDDDDDD;
        tick();
        redirect = 1'b0;
        chk("t4_cnt",   32'(buf_count),    32'd0);
        chk("t4_novld", 32'(if_valid),     32'd0);
        chk("t4_addr",  instr_mem_address, 32'h60000200);
        instr_mem_rdata = 32'hC0000200;
        tick();
        instr_mem_resp = 1'b0;
        chk("t4_vld",   32'(if_valid), 32'd1);
        chk("t4_pc",    if_pc,         32'h60000200);
        chk("t4_ir",    if_ir,         32'hC0000200);

        // Push and pop in the same cycle at count=2
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'hC0000204;
        tick();
        chk("t5_cnt2",  32'(buf_count), 32'd2);
        id_ready        = 1'b1;
        instr_mem_rdata = 32'hC0000208;
        tick();
        instr_mem_resp = 1'b0;
        chk("t5_pp_cnt", 32'(buf_count), 32'd2);
        chk("t5_pp_pc",  if_pc,          32'h60000204);
        chk("t5_pp_ir",  if_ir,          32'hC0000204);
        tick();
        chk("t5_cnt1",  32'(buf_count), 32'd1);
        chk("t5_pc3",   if_pc,          32'h60000208);
        chk("t5_ir3",   if_ir,          32'hC0000208);
        tick();
        chk("t5_empty", 32'(if_valid),  32'd0);
        chk("t5_nop",   if_ir,          32'h00000013);
        tick();
        chk("t5_popempty", 32'(buf_count),    32'd0);
        chk("t5_addr",     instr_mem_address, 32'h6000020C);
        id_ready = 1'b0;

        // Reset while discarding; stray resp during reset
        redirect    = 1'b1;
        redirect_pc = 32'h60000300;
        tick();
        redirect = 1'b0;
        chk("t6_disc_addr", instr_mem_address, 32'h6000020C);
`ifdef FETCH_QUEUE_PERF_EN
        chk("t6_perf_disc", perf_discards, 32'd3);
`endif
        rst = 1'b0;
        tick();
        chk("t6_rst_read", 32'(instr_read), 32'd0);
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'hBADBAD00;
        tick();
        instr_mem_resp = 1'b0;
        rst            = 1'b1;
        #1;
        chk("t6_addr",  instr_mem_address, 32'h60000000);
        chk("t6_cnt",   32'(buf_count),    32'd0);
        chk("t6_read",  32'(instr_read),   32'd1);
`ifdef FETCH_QUEUE_PERF_EN
        chk("t6_perf_full0", perf_full_cycles, 32'd0);
        chk("t6_perf_disc0", perf_discards,    32'd0);
`endif
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'hE0000000;
        tick();
        instr_mem_resp = 1'b0;
        chk("t6_pc",  if_pc,          32'h60000000);
        chk("t6_ir",  if_ir,          32'hE0000000);
        chk("t6_cnt1", 32'(buf_count), 32'd1);

        // Fetch PC wraps past the top of the address space
        redirect        = 1'b1;
        redirect_pc     = 32'hFFFFFFFC;
        instr_mem_resp  = 1'b1;
        instr_mem_rdata = 32'h11111111;
        tick();
        redirect        = 1'b0;
        instr_mem_rdata = 32'hF0000000;
        tick();
        instr_mem_resp = 1'b0;
        chk("wrap_pc",   if_pc,             32'hFFFFFFFC);
        chk("wrap_ir",   if_ir,             32'hF0000000);
        chk("wrap_addr", instr_mem_address, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
